// File: rtl/spike_analyzer.sv
// spike_analyzer: downstream monitor for the LIF neuron.
// Measures inter-spike intervals into a small valid/ready FIFO, keeps a
// windowed spike rate, a burst level and an optional windowed peak potential.
// Optional feature macro: SPIKE_ANALYZER_PEAK_EN builds the peak tracker;
// without it `peak` is tied to zero.
module spike_analyzer #(
   parameter int FIFO_DEPTH = 4,
   parameter int BURST_ISI  = 8,
   parameter int BURST_LEN  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       clear,
   input  logic       spike,
   input  logic [7:0] membrane_potential,
   input  logic [1:0] window_sel,
   output logic [7:0] isi_data,
   output logic       isi_valid,
   input  logic       isi_ready,
   output logic [7:0] rate,
   output logic       rate_update,
   output logic       burst,
   output logic [7:0] peak,
   output logic       overflow
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [AW-1:0] LAST_PTR  = AW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [8:0]    SHORT_MAX = 9'(BURST_ISI);
   localparam logic [7:0]    RUN_GOAL  = 8'(BURST_LEN - 1);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

   function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic inc);
      return inc ? sat_inc8(v) : v;
   endfunction

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + AW'(1);
   endfunction

   // ISI measurement and staged push
   logic [7:0]    isi_cnt_q, isi_cnt_d;
   logic          armed_q, armed_d;
   logic          pend_q, pend_d;
   logic [7:0]    pend_val_q, pend_val_d;
   // FIFO
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    isi_data_q, isi_data_d;
   logic          isi_valid_q, isi_valid_d;
   logic          overflow_q, overflow_d;
   logic          wr_en, pop;
   // burst
   logic [7:0]    run_q, run_d;
   logic          burst_q, burst_d;
   // rate window
   logic [6:0]    wcnt_q, wcnt_d, wlast_q, wlast_d;
   logic [7:0]    acc_q, acc_d, rate_q, rate_d;
   logic          rate_update_q, rate_update_d;

   logic [7:0]    wlen_sel;
   logic [6:0]    eff_last;
   logic          win_end;
   logic [7:0]    isi_val;
   logic          isi_short, isi_timeout;

   // The window length is latched at wcnt = 0, so that cycle compares
   // against the freshly selected length rather than the stale one.
   assign wlen_sel    = 8'd16 << window_sel;
   assign eff_last    = (wcnt_q == 7'd0) ? 7'(wlen_sel - 8'd1) : wlast_q;
   assign win_end     = ena & ~clear & (wcnt_q == eff_last);
   assign isi_val     = sat_inc8(isi_cnt_q);
   assign isi_short   = ({1'b0, isi_val} <= SHORT_MAX);
   assign isi_timeout = (({1'b0, isi_cnt_q} + 9'd1) > SHORT_MAX);

   // Next-state for ISI counter, FIFO, burst tracker and rate window
   always_comb begin
      isi_cnt_d     = isi_cnt_q;
      armed_d       = armed_q;
      pend_d        = pend_q;
      pend_val_d    = pend_val_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      isi_data_d    = isi_data_q;
      isi_valid_d   = isi_valid_q;
      overflow_d    = overflow_q;
      run_d         = run_q;
      burst_d       = burst_q;
      wcnt_d        = wcnt_q;
      wlast_d       = wlast_q;
      acc_d         = acc_q;
      rate_d        = rate_q;
      rate_update_d = 1'b0;
      wr_en         = 1'b0;
      pop           = 1'b0;

      if (clear) begin
         isi_cnt_d   = '0;
         armed_d     = 1'b0;
         pend_d      = 1'b0;
         pend_val_d  = '0;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
         isi_data_d  = '0;
         isi_valid_d = 1'b0;
         overflow_d  = 1'b0;
         run_d       = '0;
         burst_d     = 1'b0;
         wcnt_d      = '0;
         acc_d       = '0;
         rate_d      = '0;
      end else if (ena) begin
         // FIFO: the ISI staged last cycle is written now; a pop frees a
         // slot in the same edge, so push+pop on a full FIFO both succeed.
         pop   = isi_valid_q & isi_ready;
         wr_en = pend_q & ((count_q != FULL_CNT) | pop);
         if (pend_q && !wr_en) begin
            overflow_d = 1'b1;
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         count_d     = count_q + CW'(wr_en) - CW'(pop);
         isi_valid_d = (count_d != '0);
         if (count_d != '0) begin
            isi_data_d = (wr_en && (wr_ptr_q == rd_ptr_d)) ? pend_val_q : mem[rd_ptr_d];
         end

         // ISI counter, staging of the next push and burst run tracking
         pend_d = 1'b0;
         if (spike) begin
            isi_cnt_d = '0;
            armed_d   = 1'b1;
            if (armed_q) begin
               pend_d     = 1'b1;
               pend_val_d = isi_val;
               run_d      = isi_short ? sat_inc8(run_q) : 8'd0;
               burst_d    = (run_d >= RUN_GOAL);
            end
         end else begin
            isi_cnt_d = sat_inc8(isi_cnt_q);
            if (isi_timeout) begin
               run_d   = '0;
               burst_d = 1'b0;
            end
         end

         // Rate window
         if (wcnt_q == 7'd0) begin
            wlast_d = eff_last;
         end
         if (win_end) begin
            rate_d        = sat_add8(acc_q, spike);
            acc_d         = '0;
            rate_update_d = 1'b1;
            wcnt_d        = '0;
         end else begin
            acc_d  = sat_add8(acc_q, spike);
            wcnt_d = wcnt_q + 7'd1;
         end
      end
   end

   // Control and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isi_cnt_q     <= '0;
         armed_q       <= 1'b0;
         pend_q        <= 1'b0;
         pend_val_q    <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         isi_data_q    <= '0;
         isi_valid_q   <= 1'b0;
         overflow_q    <= 1'b0;
         run_q         <= '0;
         burst_q       <= 1'b0;
         wcnt_q        <= '0;
         wlast_q       <= '0;
         acc_q         <= '0;
         rate_q        <= '0;
         rate_update_q <= 1'b0;
      end else begin
         isi_cnt_q     <= isi_cnt_d;
         armed_q       <= armed_d;
         pend_q        <= pend_d;
         pend_val_q    <= pend_val_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         isi_data_q    <= isi_data_d;
         isi_valid_q   <= isi_valid_d;
         overflow_q    <= overflow_d;
         run_q         <= run_d;
         burst_q       <= burst_d;
         wcnt_q        <= wcnt_d;
         wlast_q       <= wlast_d;
         acc_q         <= acc_d;
         rate_q        <= rate_d;
         rate_update_q <= rate_update_d;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= pend_val_q;
      end
   end

   assign isi_data    = isi_data_q;
   assign isi_valid   = isi_valid_q;
   assign overflow    = overflow_q;
   assign burst       = burst_q;
   assign rate        = rate_q;
   assign rate_update = rate_update_q;

`ifdef SPIKE_ANALYZER_PEAK_EN
   function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [7:0] peak_run_q, peak_run_d, peak_q, peak_d;

   // Running maximum over the window, published at the window end
   always_comb begin
      peak_run_d = peak_run_q;
      peak_d     = peak_q;
      if (clear) begin
         peak_run_d = '0;
         peak_d     = '0;
      end else if (ena) begin
         if (win_end) begin
            peak_d     = max8(peak_run_q, membrane_potential);
            peak_run_d = '0;
         end else begin
            peak_run_d = max8(peak_run_q, membrane_potential);
         end
      end
   end

   // Peak registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_run_q <= '0;
         peak_q     <= '0;
      end else begin
         peak_run_q <= peak_run_d;
         peak_q     <= peak_d;
      end
   end

   assign peak = peak_q;
`else
   logic pot_unused;
   assign pot_unused = ^membrane_potential;
   assign peak       = 8'd0;
`endif

endmodule

// File: doc/spike_analyzer.md
# spike_analyzer

Downstream monitor for the LIF neuron. It consumes the neuron's registered `spike` and `membrane_potential` outputs and measures inter-spike intervals (ISIs), buffering them in a small FIFO with a valid/ready read port. It also produces a windowed spike rate, a burst flag and, optionally, a windowed peak potential for the top-level output mux.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: ISI FIFO entries (power of two).
- `BURST_ISI`, 8: maximum ISI, in cycles, counted as "short".
- `BURST_LEN`, 3: consecutive spikes with short ISIs needed to assert `burst`.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ena`  in  1: advance enable; all state frozen when low.
- `clear`  in  1: synchronous clear of all state; active regardless of `ena`.
- `spike`  in  1: neuron spike, one cycle per spike.
- `membrane_potential`  in  8: neuron potential, unsigned.
- `window_sel`  in  2: rate window length = 16 << `window_sel` cycles (16, 32, 64 or 128).
- `isi_data`  out  8: FIFO head, the ISI in cycles.
- `isi_valid`  out  1: FIFO not empty.
- `isi_ready`  in  1: consumer accepts the head.
- `rate`  out  8: spike count of the last completed window.
- `rate_update`  out  1: one-cycle pulse when `rate` is refreshed.
- `burst`  out  1: burst-in-progress level.
- `peak`  out  8: maximum potential in the last completed window.
- `overflow`  out  1: sticky flag; set when an ISI is dropped because the FIFO is full.

## Operation
- **Advance rule:** state advances only in cycles with `ena` = 1. The exception is `clear`, which has priority over everything, including `spike` and a pop.
- **ISI counter** (`isi_cnt`, 8-bit):
  - Cleared to 0 on a spike.
  - Otherwise increments each advancing cycle, saturating at 255.
  - The `armed` flag is 0 after reset or `clear` and is set by the first spike.
  - A spike while `armed` = 1 pushes min(`isi_cnt` + 1, 255). Spikes in back-to-back cycles therefore give ISI = 1.
  - The first spike after reset or clear pushes nothing.
- **FIFO:**
  - A push and a pop in the same cycle are both honoured, even when the FIFO is full.
  - A push into a full FIFO with no pop is dropped and sets `overflow`.
  - A pop occurs when `ena` & `isi_valid` & `isi_ready`.
  - When `isi_valid` = 0, `isi_data` holds its last value.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Burst:**
  - Run counter `run`: an ISI ≤ `BURST_ISI` increments it (saturating); an ISI > `BURST_ISI` resets it to 0.
  - `burst` is set when `run` reaches `BURST_LEN` − 1.
  - `burst` clears, and `run` resets, in the cycle after `isi_cnt` + 1 exceeds `BURST_ISI` with no spike.
  - ISIs feed the run counter whether or not the FIFO push is dropped.
- **Rate window:**
  - Window counter `wcnt` runs from 0 to L−1; L is latched from `window_sel` when `wcnt` = 0. Changes mid-window take effect at the next window.
  - The spike accumulator saturates at 255.
  - In the cycle where `wcnt` = L−1: `rate` ← accumulator plus the current spike (saturating), the accumulator resets, and `rate_update` pulses in the following cycle.
- **Peak:** the running maximum of `membrane_potential` over the window. At window end, `peak` ← max(running, current sample) and running ← 0.
- **Clear:** empties the FIFO and zeroes `overflow`, `isi_cnt`, `armed`, `run`, `burst`, `wcnt`, the accumulator, `rate` and `peak`. It does not pulse `rate_update`.

## Timing
- **Reset values:** `isi_data` = 0, `isi_valid` = 0, `rate` = 0, `rate_update` = 0, `burst` = 0, `peak` = 0, `overflow` = 0. Internally, `armed` = 0 and `wcnt` = 0.
- All outputs are registered.
- **Push latency:** a spike sampled at edge N into an empty FIFO gives `isi_valid` = 1 with the correct `isi_data` after edge N+1.
- **Pop:** takes effect at the edge where the handshake is seen; the next head appears in the same cycle after that edge.
- **`burst`:** updates on the edge that samples the qualifying spike.
- **Rate/peak:** `rate` and `peak` update on the edge at `wcnt` = L−1; `rate_update` is high for exactly the one following cycle.
- **`ena` low:** freezes all counters and the FIFO. A spike arriving with `ena` = 0 is ignored.
- **Async reset mid-window or mid-burst:** returns every register to its reset value immediately.

## Configuration
- **`SPIKE_ANALYZER_PEAK_EN`**
  - Defined: the peak tracker is built and `peak` behaves as described above.
  - Undefined: the tracker is not built and `peak` is constant 0.
  - All other behaviour is identical in both builds.

## Test plan
- **ISI measurement:** spikes at cycles 10, 15 and 16, `isi_ready` = 1 → no push at 10; then `isi_data` = 5 followed by 1, each with `isi_valid` high for one cycle.
- **Overflow:** `isi_ready` = 0, six spikes spaced 3 cycles apart → FIFO holds 3, 3, 3, 3 and `overflow` = 1 after the sixth spike. A simultaneous pop plus push when full → no overflow.
- **Burst:** spikes at 0, 4, 8, then 30 → `burst` rises after the spike at 8 and falls when the gap exceeds 8 cycles; the ISI of 22 keeps `run` at 0.
- **Rate window:** `window_sel` = 0, spikes every 4 cycles from cycle 0 → `rate` = 4 at each 16-cycle boundary with a one-cycle `rate_update`. Changing to `window_sel` = 1 mid-window → the next window is 32 cycles with `rate` = 8.
- **Peak:** potential ramps 50→200 within a 16-cycle window → `peak` = 200 at window end, or 0 in the macro-off build.
- **Control:** `clear` during an active burst with a full FIFO → all outputs 0 the next cycle. `ena` = 0 for 5 cycles between two spikes → measured ISI excludes the frozen cycles.
